// File: rtl/input_arbiter_pkg.sv
// Shared encodings for the cursor input arbiter (owner codes, FSM states, widths).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package input_arb_pkg;

    localparam int COORD_W   = 12;
    localparam int BTN_W     = 8;
    localparam int DROP_W    = 8;
    localparam int CLICK_BIT = 0;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_BT   = 2'd1;
    localparam logic [1:0] OWN_KB   = 2'd2;

    // State codes equal the owner codes so owner_o is the state register itself
    typedef enum logic [1:0] {
        S_IDLE   = OWN_NONE,
        S_OWN_BT = OWN_BT,
        S_OWN_KB = OWN_KB
    } arb_state_t;

    // Unsigned clamp of a coordinate to the last visible pixel
    function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                       input logic [COORD_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/input_arbiter_if.sv
// Bundle of source samples, game busy and arbitrated cursor outputs.
// Latency: n/a (wires only).
// Backpressure: busy_i is the only backpressure; samples are strobes.
interface input_arbiter_if
    import input_arb_pkg::*;
;
    logic               bt_valid;
    logic [COORD_W-1:0] bt_x;
    logic [COORD_W-1:0] bt_y;
    logic [BTN_W-1:0]   bt_btn;
    logic               kb_valid;
    logic [COORD_W-1:0] kb_x;
    logic [COORD_W-1:0] kb_y;
    logic [BTN_W-1:0]   kb_btn;
    logic               busy_i;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic               valid_o;
    logic               click_o;
    logic [1:0]         owner_o;
    logic [DROP_W-1:0]  drop_cnt_o;

    // Decoders and game side
    modport master (
        output bt_valid, bt_x, bt_y, bt_btn,
        output kb_valid, kb_x, kb_y, kb_btn,
        output busy_i,
        input  cur_x, cur_y, valid_o, click_o, owner_o, drop_cnt_o
    );

    // Arbiter side
    modport slave (
        input  bt_valid, bt_x, bt_y, bt_btn,
        input  kb_valid, kb_x, kb_y, kb_btn,
        input  busy_i,
        output cur_x, cur_y, valid_o, click_o, owner_o, drop_cnt_o
    );

endinterface

// File: rtl/input_arbiter_src_edge_tracker.sv
// Remembers one source's last place-stone level and flags its rising edge.
// Latency: rise is combinational with the sample; history updates on the clock.
// Backpressure: none, every valid sample is absorbed.
module src_edge_tracker
    import input_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [BTN_W-1:0] btn,
    output logic             rise
);

    logic prev_click;
    logic unused_btn;

    // Only the place-stone bit matters to the arbiter
    assign unused_btn = ^(btn & ~(BTN_W'(1) << CLICK_BIT));

    // History follows every sample of this source, whether it owns the cursor or not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prev_click <= 1'b0;
        else if (valid)
            prev_click <= btn[CLICK_BIT];
    end

    assign rise = valid & btn[CLICK_BIT] & ~prev_click;

endmodule

// File: rtl/input_arbiter.sv
// Grants the game cursor to Bluetooth or keys; forwards clamped position and click edges.
// Latency: 1 cycle sample -> cur_x/cur_y/valid_o/owner_o/click_o.
// Backpressure: busy_i holds one click pending; further clicks while pending are lost.
// Optional owner-idle release is built when INPUT_ARB_TIMEOUT_EN is defined.
module input_arbiter
    import input_arb_pkg::*;
#(
    parameter int X_START      = 320,
    parameter int Y_START      = 240,
    parameter int X_MAX        = 640,
    parameter int Y_MAX        = 480,
    parameter int IDLE_TIMEOUT = 50_000_000
) (
    input logic           clk,
    input logic           rst_n,
    input_arbiter_if.slave bus
);

    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(X_MAX - 1);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(Y_MAX - 1);

    if (IDLE_TIMEOUT < 2 || X_MAX < 1 || Y_MAX < 1) begin : g_param_check
        $error("input_arbiter: IDLE_TIMEOUT must be >= 2 and screen bounds >= 1");
    end

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic               bt_rise;
    logic               kb_rise;
    logic               load;
    logic               load_kb;
    logic               click_req;
    logic               drop;
    logic               timeout;
    logic [COORD_W-1:0] sel_x;
    logic [COORD_W-1:0] sel_y;
    logic [COORD_W-1:0] cur_x_q;
    logic [COORD_W-1:0] cur_y_q;
    logic               valid_q;
    logic               click_q;
    logic               pending;
    logic [DROP_W-1:0]  drop_cnt;

    src_edge_tracker u_bt_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (bus.bt_valid),
        .btn   (bus.bt_btn),
        .rise  (bt_rise)
    );

    src_edge_tracker u_kb_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (bus.kb_valid),
        .btn   (bus.kb_btn),
        .rise  (kb_rise)
    );

`ifdef INPUT_ARB_TIMEOUT_EN
    localparam int TW = $clog2(IDLE_TIMEOUT);
    logic [TW-1:0] idle_cnt;

    assign timeout = (state != S_IDLE) && (idle_cnt == TW'(IDLE_TIMEOUT - 1));

    // Counts owner silence; any loaded sample, idle state or release restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt <= '0;
        else if (load || state == S_IDLE || timeout)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Ownership decisions: owner sample wins, non-owner rise takes over, else drop
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_kb   = 1'b0;
        click_req = 1'b0;
        drop      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.bt_valid) begin
                    state_nxt = S_OWN_BT;
                    load      = 1'b1;
                    click_req = bt_rise;
                    drop      = bus.kb_valid;
                end else if (bus.kb_valid) begin
                    state_nxt = S_OWN_KB;
                    load      = 1'b1;
                    load_kb   = 1'b1;
                    click_req = kb_rise;
                end
            end
            S_OWN_BT: begin
                if (bus.bt_valid) begin
                    load      = 1'b1;
                    click_req = bt_rise;
                    drop      = bus.kb_valid;
                end else if (bus.kb_valid) begin
                    if (kb_rise) begin
                        state_nxt = S_OWN_KB;
                        load      = 1'b1;
                        load_kb   = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            S_OWN_KB: begin
                if (bus.kb_valid) begin
                    load      = 1'b1;
                    load_kb   = 1'b1;
                    click_req = kb_rise;
                    drop      = bus.bt_valid;
                end else if (bus.bt_valid) begin
                    if (bt_rise) begin
                        state_nxt = S_OWN_BT;
                        load      = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (timeout && !load)
            state_nxt = S_IDLE;
    end

    // Owner mirror and source select for the position load
    always_comb begin
        bus.owner_o = state;
        sel_x       = load_kb ? bus.kb_x : bus.bt_x;
        sel_y       = load_kb ? bus.kb_y : bus.bt_y;
    end

    // Cursor position, update strobe and saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x_q  <= COORD_W'(X_START);
            cur_y_q  <= COORD_W'(Y_START);
            valid_q  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            valid_q <= load;
            if (load) begin
                cur_x_q <= clamp_coord(sel_x, X_LIM);
                cur_y_q <= clamp_coord(sel_y, Y_LIM);
            end
            if (drop && drop_cnt != {DROP_W{1'b1}})
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Click delivery with a single-deep hold while the game is busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            click_q <= 1'b0;
            pending <= 1'b0;
        end else begin
            click_q <= 1'b0;
            if (pending) begin
                if (!bus.busy_i) begin
                    click_q <= 1'b1;
                    pending <= 1'b0;
                end
            end else if (click_req) begin
                if (bus.busy_i)
                    pending <= 1'b1;
                else
                    click_q <= 1'b1;
            end
        end
    end

    assign bus.cur_x      = cur_x_q;
    assign bus.cur_y      = cur_y_q;
    assign bus.valid_o    = valid_q;
    assign bus.click_o    = click_q;
    assign bus.drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_input_arbiter.sv
// Self-checking bench for input_arbiter: directed table, corner sequences, random vs model.
// Latency: expects outputs one cycle after each applied sample.
// Backpressure: busy_i driven directly by the bench.
module tb_input_arbiter;

    localparam int TO   = 16;
    localparam int XLIM = 639;
    localparam int YLIM = 479;

    logic clk;
    logic rst_n;

    input_arbiter_if bus ();

    input_arbiter #(
        .X_START      (320),
        .Y_START      (240),
        .X_MAX        (640),
        .Y_MAX        (480),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit       bv;
        int       bx;
        int       by;
        bit [7:0] bb;
        bit       kv;
        int       kx;
        int       ky;
        bit [7:0] kb;
        bit       busy;
    } stim_t;

    typedef struct {
        stim_t s;
        int    ex;
        int    ey;
        bit    ev;
        bit    ec;
        int    eo;
        int    ed;
    } vec_t;

    // Reference model state: who owns the cursor and what each source last pressed
    int m_owner, m_x, m_y, m_drop, m_cnt;
    bit m_prev_bt, m_prev_kb, m_pending, m_valid, m_click;

    function automatic void model_reset();
        m_owner = 0; m_x = 320; m_y = 240; m_drop = 0; m_cnt = 0;
        m_prev_bt = 0; m_prev_kb = 0; m_pending = 0; m_valid = 0; m_click = 0;
    endfunction

    function automatic void model_step(input stim_t s);
        bit rb, rk, req, own_v, own_r, oth_v, oth_r;
        int served, ndrop, prev_owner, other;
        rb = s.bv && s.bb[0] && !m_prev_bt;
        rk = s.kv && s.kb[0] && !m_prev_kb;
        served = 0; req = 0; ndrop = 0; prev_owner = m_owner;
        if (m_owner == 0) begin
            if (s.bv) begin served = 1; req = rb; ndrop = s.kv ? 1 : 0; end
            else if (s.kv) begin served = 2; req = rk; end
        end else begin
            other = 3 - m_owner;
            own_v = (m_owner == 1) ? s.bv : s.kv;
            own_r = (m_owner == 1) ? rb : rk;
            oth_v = (m_owner == 1) ? s.kv : s.bv;
            oth_r = (m_owner == 1) ? rk : rb;
            if (own_v) begin served = m_owner; req = own_r; ndrop = oth_v ? 1 : 0; end
            else if (oth_v) begin
                if (oth_r) served = other;
                else ndrop = 1;
            end
        end
        m_valid = (served != 0);
        if (served != 0) begin
            m_owner = served;
            m_x = (served == 1) ? s.bx : s.kx;
            m_y = (served == 1) ? s.by : s.ky;
            if (m_x > XLIM) m_x = XLIM;
            if (m_y > YLIM) m_y = YLIM;
        end
        m_click = 0;
        if (m_pending) begin
            if (!s.busy) begin m_click = 1; m_pending = 0; end
        end else if (req) begin
            if (s.busy) m_pending = 1;
            else m_click = 1;
        end
`ifdef INPUT_ARB_TIMEOUT_EN
        if (served != 0 || prev_owner == 0) m_cnt = 0;
        else if (m_cnt == TO - 1) begin m_owner = 0; m_cnt = 0; end
        else m_cnt++;
`endif
        m_drop = m_drop + ndrop;
        if (m_drop > 255) m_drop = 255;
        if (s.bv) m_prev_bt = s.bb[0];
        if (s.kv) m_prev_kb = s.kb[0];
    endfunction

    task automatic apply(input stim_t s);
        bus.bt_valid = s.bv;
        bus.bt_x     = 12'(s.bx);
        bus.bt_y     = 12'(s.by);
        bus.bt_btn   = s.bb;
        bus.kb_valid = s.kv;
        bus.kb_x     = 12'(s.kx);
        bus.kb_y     = 12'(s.ky);
        bus.kb_btn   = s.kb;
        bus.busy_i   = s.busy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input int ex, input int ey,
                             input bit ev, input bit ec, input int eo, input int ed);
        logic [35:0] act;
        logic [35:0] exp;
        act = {bus.cur_x, bus.cur_y, bus.valid_o, bus.click_o, bus.owner_o, bus.drop_cnt_o};
        exp = {12'(ex), 12'(ey), ev, ec, 2'(eo), 8'(ed)};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got x=%0d y=%0d v=%0b c=%0b own=%0d drop=%0d, want x=%0d y=%0d v=%0b c=%0b own=%0d drop=%0d",
                     name, bus.cur_x, bus.cur_y, bus.valid_o, bus.click_o, bus.owner_o,
                     bus.drop_cnt_o, ex, ey, ev, ec, eo, ed);
        end
    endtask

    task automatic do_reset();
        stim_t z;
        z = '{default: 0};
        apply(z);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t  vecs[14];
    stim_t s;
    stim_t idle;
    int    exp_own_to;

    initial begin
        idle = '{default: 0};
        rst_n = 1'b0;
        apply(idle);
        #12;
        check_out("reset", 320, 240, 0, 0, 0, 0);
        rst_n = 1'b1;

        //             bv  bx   by  bb kv  kx   ky  kb busy    ex   ey  v  c  own drop
        vecs[0]  = '{'{1, 100,  50, 0, 0,   0,   0, 0, 0}, 100,  50, 1, 0, 1, 0};
        vecs[1]  = '{'{0,   0,   0, 0, 0,   0,   0, 0, 0}, 100,  50, 0, 0, 1, 0};
        vecs[2]  = '{'{1, 110,  60, 1, 0,   0,   0, 0, 0}, 110,  60, 1, 1, 1, 0};
        vecs[3]  = '{'{0,   0,   0, 0, 0,   0,   0, 0, 0}, 110,  60, 0, 0, 1, 0};
        vecs[4]  = '{'{0,   0,   0, 0, 1,   5,   5, 0, 0}, 110,  60, 0, 0, 1, 1};
        vecs[5]  = '{'{0,   0,   0, 0, 1, 700, 500, 1, 0}, 639, 479, 1, 0, 2, 1};
        vecs[6]  = '{'{0,   0,   0, 0, 0,   0,   0, 0, 0}, 639, 479, 0, 0, 2, 1};
        vecs[7]  = '{'{0,   0,   0, 0, 1,  10,  20, 0, 1},  10,  20, 1, 0, 2, 1};
        vecs[8]  = '{'{0,   0,   0, 0, 1,  11,  20, 1, 1},  11,  20, 1, 0, 2, 1};
        vecs[9]  = '{'{0,   0,   0, 0, 1,  12,  20, 0, 1},  12,  20, 1, 0, 2, 1};
        vecs[10] = '{'{0,   0,   0, 0, 1,  13,  20, 1, 1},  13,  20, 1, 0, 2, 1};
        vecs[11] = '{'{0,   0,   0, 0, 0,   0,   0, 0, 1},  13,  20, 0, 0, 2, 1};
        vecs[12] = '{'{0,   0,   0, 0, 0,   0,   0, 0, 0},  13,  20, 0, 1, 2, 1};
        vecs[13] = '{'{0,   0,   0, 0, 0,   0,   0, 0, 0},  13,  20, 0, 0, 2, 1};

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].s);
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ev,
                      vecs[i].ec, vecs[i].eo, vecs[i].ed);
        end

        // Simultaneous grant from IDLE, then drop counter saturation
        do_reset();
        s = '{1, 1, 2, 0, 1, 3, 4, 0, 0};
        apply(s);
        tick();
        check_out("both_from_idle", 1, 2, 1, 0, 1, 1);
        for (int i = 0; i < 300; i++) begin
            apply(s);
            tick();
        end
        check_out("drop_saturate", 1, 2, 1, 0, 1, 255);

        // Owner silence: released after TO idle cycles only when the timeout is built
        apply(idle);
        for (int i = 0; i < TO - 1; i++) tick();
        check_out("pre_timeout", 1, 2, 0, 0, 1, 255);
        tick();
`ifdef INPUT_ARB_TIMEOUT_EN
        exp_own_to = 0;
`else
        exp_own_to = 1;
`endif
        check_out("timeout", 1, 2, 0, 0, exp_own_to, 255);

        // Pending click wiped by an asynchronous reset in mid-cycle
        s = '{1, 5, 6, 0, 0, 0, 0, 0, 1};
        apply(s);
        tick();
        s.bb = 8'h01;
        apply(s);
        tick();
        check_out("pending_armed", 5, 6, 1, 0, 1, 255);
        apply(idle);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 320, 240, 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("no_click_after_reset%0d", i), 320, 240, 0, 0, 0, 0);
        end

        // Random traffic against the reference model
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            s.bv   = ($urandom_range(0, 9) < 3);
            s.bx   = $urandom_range(0, 1) ? int'($urandom_range(0, 700)) : int'($urandom_range(0, 4095));
            s.by   = $urandom_range(0, 1) ? int'($urandom_range(0, 520)) : int'($urandom_range(0, 4095));
            s.bb   = 8'($urandom_range(0, 255));
            s.kv   = ($urandom_range(0, 9) < 3);
            s.kx   = $urandom_range(0, 1) ? int'($urandom_range(0, 700)) : int'($urandom_range(0, 4095));
            s.ky   = $urandom_range(0, 1) ? int'($urandom_range(0, 520)) : int'($urandom_range(0, 4095));
            s.kb   = 8'($urandom_range(0, 255));
            s.busy = $urandom_range(0, 1);
            model_step(s);
            apply(s);
            tick();
            check_out($sformatf("rand%0d", i), m_x, m_y, m_valid, m_click, m_owner, m_drop);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_arbiter.md
# input_arbiter

Shares the game cursor between two input sources: the Bluetooth remote path (decoded cursor sums and button byte) and the on-board key path. Grants cursor ownership to one source at a time, forwards the owner's position (clamped to screen) and button-click edges to the gobang game logic, and holds clicks while the game logic is busy. Sits between the input decoders and the game/board controller.

## Interface
- X_START, 320, cursor X after reset
- Y_START, 240, cursor Y after reset
- X_MAX, 640, exclusive X bound; outputs clamped to X_MAX-1
- Y_MAX, 480, exclusive Y bound; outputs clamped to Y_MAX-1
- IDLE_TIMEOUT, 50_000_000, owner-idle cycles before release (used only with the timeout feature)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- bt_valid  in  1  one-cycle strobe, Bluetooth sample present
- bt_x, bt_y  in  12 each  Bluetooth cursor position
- bt_btn  in  8  Bluetooth button byte, level; bit0 = place-stone
- kb_valid  in  1  one-cycle strobe, key-path sample present
- kb_x, kb_y  in  12 each  key-path cursor position
- kb_btn  in  8  key-path button byte, level; bit0 = place-stone
- busy_i  in  1  game logic cannot accept a click
- cur_x, cur_y  out  12 each  registered cursor position
- valid_o  out  1  one-cycle strobe, cur_x/cur_y updated
- click_o  out  1  one-cycle place-stone strobe
- owner_o  out  2  0 = none, 1 = Bluetooth, 2 = keys
- drop_cnt_o  out  8  saturating count of discarded non-owner samples

## Operation
- States: IDLE, OWN_BT, OWN_KB; owner_o mirrors state.
- IDLE: bt_valid -> OWN_BT; else kb_valid -> OWN_KB. The granting sample is processed as an owner sample. Both valid same cycle: Bluetooth wins, key sample dropped (drop_cnt_o +1).
- Owner sample: cur_x = min(x, X_MAX-1), cur_y = min(y, Y_MAX-1) (unsigned), valid_o pulses; rising edge of bit0 versus that source's previous sampled btn raises a click request.
- Non-owner sample with bit0 rising: takeover — state switches to that source, its position is loaded, valid_o pulses, the click itself is consumed (not forwarded).
- Non-owner sample without takeover: discarded, drop_cnt_o +1, saturates at 255.
- Owner and non-owner valid in same cycle: owner sample processed, non-owner dropped (no takeover).
- Per-source previous-btn register updates on every valid of that source, owner or not.
- Click request: busy_i low -> click_o next cycle; busy_i high -> pending flag set, click_o issued the first cycle busy_i is low. A request while pending is dropped (single-deep). Pending survives ownership change.

## Timing
- Reset values: cur_x = X_START, cur_y = Y_START, valid_o = 0, click_o = 0, owner_o = 0, drop_cnt_o = 0, pending = 0, previous btn = 0, timeout counter = 0.
- Latency: valid input at cycle N -> cur_x/cur_y/valid_o/owner_o at N+1; click_o at N+1 if busy_i low at N.
- Pending release: busy_i low at cycle M -> click_o at M+1.
- click_o and valid_o are never high two consecutive cycles for one event.
- Reset asserted mid-operation clears state, pending click and counters asynchronously; no click_o after release.

## Configuration
- INPUT_ARB_TIMEOUT_EN defined: counter clears on each owner sample, increments otherwise in OWN_*; on reaching IDLE_TIMEOUT-1 the state returns to IDLE next cycle (owner_o = 0, cur_x/cur_y retained).
- Not defined: no counter; ownership changes only by takeover; IDLE_TIMEOUT ignored.

## Structure
- Package input_arb_pkg: owner encoding constants (OWN_NONE=0, OWN_BT=1, OWN_KB=2), state typedef, click bit index (0).
- Sub-module src_edge_tracker, instantiated twice: holds a source's previous btn and produces the bit0-rise flag on valid.

## Test plan
- Reset, then bt_valid with (100,50,btn=0) -> one cycle later cur=(100,50), valid_o=1, owner_o=1.
- Owner BT, bt_btn bit0 0->1 with busy_i=0 -> click_o=1 exactly one cycle; kb_valid without click -> dropped, drop_cnt_o=1.
- Owner BT, kb_valid with kb_btn 0->1 at (700,500) -> owner_o=2, cur=(639,479), click_o stays 0.
- busy_i=1, owner click, second owner click -> no click_o; busy_i falls -> single click_o next cycle.
- bt_valid and kb_valid same cycle from IDLE -> owner_o=1, drop_cnt_o=1; 300 non-owner samples -> drop_cnt_o=255.
- With INPUT_ARB_TIMEOUT_EN, IDLE_TIMEOUT=16: no owner samples for 16 cycles -> owner_o=0, cur unchanged; without macro owner_o remains 1.
